// File: rtl/ssd1306_power_sequencer_if.sv
// Byte-level link between the SSD1306 power sequencer, the user byte source
// and the downstream SPI byte serialiser.
interface ssd1306_power_sequencer_if;
    // User byte handshake
    logic        usr_valid;
    logic        usr_dc;
    logic [7:0]  usr_data;
    logic        usr_ready;

    // Serialiser side
    logic        spi_data_ready;
    logic        spi_data_u8;
    logic [31:0] spi_data;
    logic        spi_busy;

    // Sequencer view: accepts user bytes, drives the serialiser
    modport master (
        input  usr_valid,
        input  usr_dc,
        input  usr_data,
        output usr_ready,
        output spi_data_ready,
        output spi_data_u8,
        output spi_data,
        input  spi_busy
    );

    // Environment view: offers user bytes, consumes serialiser strobes
    modport slave (
        output usr_valid,
        output usr_dc,
        output usr_data,
        input  usr_ready,
        input  spi_data_ready,
        input  spi_data_u8,
        input  spi_data,
        output spi_busy
    );
endinterface

// File: rtl/ssd1306_power_sequencer.sv
// SSD1306 power sequencer: owns the rails, reset pin and D/C line, runs the
// fixed power-up command list, forwards user bytes one at a time and runs the
// power-down sequence on request.
module ssd1306_power_sequencer #(
    parameter int DELAY_1MS   = 100000,
    parameter int DELAY_100MS = 10000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic shutdown,
    ssd1306_power_sequencer_if.master bus,
    output logic oled_dc,
    output logic oled_res_n,
    output logic oled_vdd_n,
    output logic oled_vbat_n,
    output logic ready
);

    localparam int DELAY_MAX = (DELAY_100MS > DELAY_1MS) ? DELAY_100MS : DELAY_1MS;
    localparam int CNT_W     = (DELAY_MAX > 1) ? $clog2(DELAY_MAX) : 1;
    localparam logic [CNT_W-1:0] LD_1MS   = CNT_W'(DELAY_1MS - 1);
    localparam logic [CNT_W-1:0] LD_100MS = CNT_W'(DELAY_100MS - 1);

    typedef enum logic [3:0] {
        S_OFF, S_VDD_WAIT, S_CMD_OFF, S_RES_LO, S_RES_HI, S_CMD_PWR,
        S_VBAT_WAIT, S_CMD_CFG, S_ON, S_USR_SEND, S_SD_CMD, S_SD_WAIT
    } state_t;

    // Progress of the byte currently handed to the serialiser
    typedef enum logic [1:0] {
        PH_IDLE, PH_STROBE, PH_WAIT_HI, PH_WAIT_LO
    } phase_t;

    // Power-up command list; entry 0 (display off) is reused by power-down
    function automatic logic [7:0] cmd_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    cmd_rom = 8'hAE;
            4'd1:    cmd_rom = 8'h8D;
            4'd2:    cmd_rom = 8'h14;
            4'd3:    cmd_rom = 8'hD9;
            4'd4:    cmd_rom = 8'hF1;
            4'd5:    cmd_rom = 8'h81;
            4'd6:    cmd_rom = 8'h0F;
            4'd7:    cmd_rom = 8'hA1;
            4'd8:    cmd_rom = 8'hC8;
            4'd9:    cmd_rom = 8'hDA;
            4'd10:   cmd_rom = 8'h20;
            4'd11:   cmd_rom = 8'hAF;
            default: cmd_rom = 8'h00;
        endcase
    endfunction

    state_t           state, state_n;
    phase_t           phase, phase_n;
    logic [3:0]       ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sd_latch, sd_latch_n;
    logic [7:0]       byte_q, byte_n;
    logic             dc_q, dc_n;
    logic             vdd_n_q, vdd_n_n;
    logic             vbat_n_q, vbat_n_n;
    logic             res_n_q;

    logic             send_done;
    logic             load;
    logic [7:0]       load_byte;
    logic             load_dc;

    // State, counters, held byte and pin registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_OFF;
            phase    <= PH_IDLE;
            ptr      <= 4'd0;
            cnt      <= '0;
            sd_latch <= 1'b0;
            byte_q   <= 8'h00;
            dc_q     <= 1'b0;
            vdd_n_q  <= 1'b1;
            vbat_n_q <= 1'b1;
            res_n_q  <= 1'b1;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            sd_latch <= sd_latch_n;
            byte_q   <= byte_n;
            dc_q     <= dc_n;
            vdd_n_q  <= vdd_n_n;
            vbat_n_q <= vbat_n_n;
            res_n_q  <= (state_n != S_RES_LO);
        end
    end

    // Next-state logic: sequence steps, byte send phases and shutdown latch
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        ptr_n      = ptr;
        cnt_n      = cnt;
        sd_latch_n = sd_latch;
        byte_n     = byte_q;
        dc_n       = dc_q;
        vdd_n_n    = vdd_n_q;
        vbat_n_n   = vbat_n_q;
        load       = 1'b0;
        load_byte  = 8'h00;
        load_dc    = 1'b0;

        send_done = (phase == PH_WAIT_LO) && !bus.spi_busy;

        case (phase)
            PH_STROBE:  phase_n = PH_WAIT_HI;
            PH_WAIT_HI: if (bus.spi_busy) phase_n = PH_WAIT_LO;
            PH_WAIT_LO: if (!bus.spi_busy) phase_n = PH_IDLE;
            default:    phase_n = PH_IDLE;
        endcase

        if (shutdown && state != S_OFF)
            sd_latch_n = 1'b1;

        case (state)
            S_OFF: begin
                if (start) begin
                    state_n = S_VDD_WAIT;
                    cnt_n   = LD_1MS;
                    vdd_n_n = 1'b0;
                end
            end
            S_VDD_WAIT: begin
                if (cnt == '0) begin
                    state_n   = S_CMD_OFF;
                    load      = 1'b1;
                    load_byte = cmd_rom(ptr);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_CMD_OFF: begin
                if (send_done) begin
                    ptr_n   = ptr + 4'd1;
                    state_n = S_RES_LO;
                    cnt_n   = LD_1MS;
                end
            end
            S_RES_LO: begin
                if (cnt == '0) begin
                    state_n = S_RES_HI;
                    cnt_n   = LD_1MS;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_RES_HI: begin
                if (cnt == '0) begin
                    state_n   = S_CMD_PWR;
                    load      = 1'b1;
                    load_byte = cmd_rom(ptr);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_CMD_PWR: begin
                if (send_done) begin
                    ptr_n = ptr + 4'd1;
                    if (ptr == 4'd4) begin
                        state_n  = S_VBAT_WAIT;
                        cnt_n    = LD_100MS;
                        vbat_n_n = 1'b0;
                    end else begin
                        load      = 1'b1;
                        load_byte = cmd_rom(ptr + 4'd1);
                    end
                end
            end
            S_VBAT_WAIT: begin
                if (cnt == '0) begin
                    state_n   = S_CMD_CFG;
                    load      = 1'b1;
                    load_byte = cmd_rom(ptr);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_CMD_CFG: begin
                if (send_done) begin
                    ptr_n = ptr + 4'd1;
                    if (ptr == 4'd11) begin
                        state_n = S_ON;
                    end else begin
                        load      = 1'b1;
                        load_byte = cmd_rom(ptr + 4'd1);
                    end
                end
            end
            S_ON: begin
                // A pending or same-cycle shutdown takes priority over a user byte
                if (sd_latch || shutdown) begin
                    state_n    = S_SD_CMD;
                    sd_latch_n = 1'b0;
                    load       = 1'b1;
                    load_byte  = cmd_rom(4'd0);
                end else if (bus.usr_valid) begin
                    state_n   = S_USR_SEND;
                    load      = 1'b1;
                    load_byte = bus.usr_data;
                    load_dc   = bus.usr_dc;
                end
            end
            S_USR_SEND: begin
                if (send_done)
                    state_n = S_ON;
            end
            S_SD_CMD: begin
                if (send_done) begin
                    state_n  = S_SD_WAIT;
                    cnt_n    = LD_100MS;
                    vbat_n_n = 1'b1;
                end
            end
            S_SD_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_OFF;
                    vdd_n_n = 1'b1;
                    ptr_n   = 4'd0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = S_OFF;
        endcase

        // Starting a byte: byte and D/C are captured here and held until done
        if (load) begin
            phase_n = PH_STROBE;
            byte_n  = load_byte;
            dc_n    = load_dc;
        end
    end

    assign bus.usr_ready      = (state == S_ON) && !sd_latch && !shutdown;
    assign bus.spi_data_ready = (phase == PH_STROBE);
    assign bus.spi_data_u8    = 1'b1;
    assign bus.spi_data       = {24'h000000, byte_q};

    assign ready       = (state == S_ON);
    assign oled_dc     = dc_q;
    assign oled_res_n  = res_n_q;
    assign oled_vdd_n  = vdd_n_q;
    assign oled_vbat_n = vbat_n_q;

endmodule

// File: tb/tb_ssd1306_power_sequencer.sv
// Directed bench for the SSD1306 power sequencer with a simple serialiser model.
module tb_ssd1306_power_sequencer;

    localparam int D1   = 10;
    localparam int D100 = 50;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic shutdown = 1'b0;
    logic oled_dc, oled_res_n, oled_vdd_n, oled_vbat_n, ready;

    ssd1306_power_sequencer_if bus_if();

    ssd1306_power_sequencer #(
        .DELAY_1MS   (D1),
        .DELAY_100MS (D100)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .shutdown    (shutdown),
        .bus         (bus_if),
        .oled_dc     (oled_dc),
        .oled_res_n  (oled_res_n),
        .oled_vdd_n  (oled_vdd_n),
        .oled_vbat_n (oled_vbat_n),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Serialiser model: busy one cycle after the strobe, for 20 cycles
    logic model_en = 1'b1;
    int   busy_cnt = 0;
    always @(posedge clk or negedge resetn) begin
        if (!resetn || !model_en)         busy_cnt <= 0;
        else if (bus_if.spi_data_ready)   busy_cnt <= 20;
        else if (busy_cnt > 0)            busy_cnt <= busy_cnt - 1;
    end
    assign bus_if.spi_busy = (busy_cnt != 0);

    // Strobe logger
    logic [7:0] log_b  [64];
    logic       log_dc [64];
    int         log_n = 0;
    always @(posedge clk) begin
        if (bus_if.spi_data_ready && log_n < 64) begin
            log_b[log_n]  <= bus_if.spi_data[7:0];
            log_dc[log_n] <= oled_dc;
            log_n         <= log_n + 1;
        end
    end

    logic [7:0] exp_seq [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                 8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_vdd_n"},  32'(oled_vdd_n), 32'd1);
        chk({tag, "_vbat_n"}, 32'(oled_vbat_n), 32'd1);
        chk({tag, "_res_n"},  32'(oled_res_n), 32'd1);
        chk({tag, "_dc"},     32'(oled_dc), 32'd0);
        chk({tag, "_strobe"}, 32'(bus_if.spi_data_ready), 32'd0);
        chk({tag, "_data"},   bus_if.spi_data, 32'h0);
        chk({tag, "_u8"},     32'(bus_if.spi_data_u8), 32'd1);
        chk({tag, "_usr_rdy"},32'(bus_if.usr_ready), 32'd0);
        chk({tag, "_ready"},  32'(ready), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        int bad;
        logic saw_busy;
        logic anydc;

        bus_if.usr_valid = 1'b0;
        bus_if.usr_dc    = 1'b0;
        bus_if.usr_data  = 8'h00;

        // Reset state
        tick(3);
        check_reset("rst");
        resetn = 1'b1;
        tick(2);
        chk("off_vdd_n", 32'(oled_vdd_n), 32'd1);

        // First power-up
        base = log_n;
        start = 1'b1; tick(1); start = 1'b0;
        chk("vdd_fall", 32'(oled_vdd_n), 32'd0);
        n = 0;
        while (!bus_if.spi_data_ready && n < 100) begin tick(1); n++; end
        chk("vdd_to_strobe", n, 32'd10);
        chk("first_byte", bus_if.spi_data, 32'h000000AE);
        chk("first_dc", 32'(oled_dc), 32'd0);

        n = 0;
        while (oled_res_n && n < 200) begin tick(1); n++; end
        n = 0;
        while (!oled_res_n && n < 200) begin tick(1); n++; end
        chk("res_lo_len", n, 32'd10);

        // Start mid-init must be ignored
        tick(2);
        start = 1'b1; tick(1); start = 1'b0;

        n = 0;
        while (oled_vbat_n && n < 1000) begin tick(1); n++; end
        chk("vbat_fall", 32'(oled_vbat_n), 32'd0);
        chk("vbat_after_count", log_n - base, 32'd5);
        chk("vbat_after_f1", 32'(log_b[base + 4]), 32'h F1);
        chk("vbat_busy_idle", 32'(bus_if.spi_busy), 32'd0);

        n = 0;
        while (!ready && n < 2000) begin tick(1); n++; end
        chk("ready_after_init", 32'(ready), 32'd1);
        chk("init_count", log_n - base, 32'd12);
        anydc = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("init_byte%0d", i), 32'(log_b[base + i]), 32'(exp_seq[i]));
            anydc = anydc | log_dc[base + i];
        end
        chk("init_dc", 32'(anydc), 32'd0);
        chk("on_usr_ready", 32'(bus_if.usr_ready), 32'd1);
        chk("on_busy_idle", 32'(bus_if.spi_busy), 32'd0);

        // User data byte
        base = log_n;
        bus_if.usr_valid = 1'b1; bus_if.usr_dc = 1'b1; bus_if.usr_data = 8'hA5;
        tick(1);
        bus_if.usr_valid = 1'b0; bus_if.usr_dc = 1'b0; bus_if.usr_data = 8'h00;
        chk("usr_hs_usr_ready", 32'(bus_if.usr_ready), 32'd0);
        chk("usr_hs_ready", 32'(ready), 32'd0);
        chk("usr_strobe", 32'(bus_if.spi_data_ready), 32'd1);
        chk("usr_byte", bus_if.spi_data, 32'h000000A5);
        chk("usr_dc", 32'(oled_dc), 32'd1);
        bad = 0; saw_busy = 1'b0; n = 0;
        while (!ready && n < 200) begin
            if (bus_if.spi_data !== 32'h000000A5 || oled_dc !== 1'b1 || bus_if.usr_ready !== 1'b0)
                bad++;
            if (bus_if.spi_busy) saw_busy = 1'b1;
            tick(1); n++;
        end
        chk("usr_hold", bad, 32'd0);
        chk("usr_saw_busy", 32'(saw_busy), 32'd1);
        chk("usr_ready_back", 32'(ready), 32'd1);
        chk("usr_busy_done", 32'(bus_if.spi_busy), 32'd0);
        chk("usr_count", log_n - base, 32'd1);

        // Shutdown and user byte in the same cycle
        base = log_n;
        shutdown = 1'b1;
        bus_if.usr_valid = 1'b1; bus_if.usr_dc = 1'b1; bus_if.usr_data = 8'h3C;
        #1;
        chk("sd_vs_usr_ready", 32'(bus_if.usr_ready), 32'd0);
        tick(1);
        shutdown = 1'b0;
        bus_if.usr_valid = 1'b0; bus_if.usr_dc = 1'b0; bus_if.usr_data = 8'h00;
        chk("sd_strobe", 32'(bus_if.spi_data_ready), 32'd1);
        chk("sd_byte", bus_if.spi_data, 32'h000000AE);
        chk("sd_dc", 32'(oled_dc), 32'd0);
        n = 0;
        while (!oled_vbat_n && n < 200) begin tick(1); n++; end
        chk("sd_vbat_rise", 32'(oled_vbat_n), 32'd1);
        chk("sd_count", log_n - base, 32'd1);
        n = 0;
        while (!oled_vdd_n && n < 200) begin tick(1); n++; end
        chk("sd_vdd_delay", n, 32'd50);
        chk("sd_off_ready", 32'(ready), 32'd0);

        // Second power-up, shutdown pulsed during the 100 ms rail wait
        base = log_n;
        start = 1'b1; tick(1); start = 1'b0;
        n = 0;
        while (oled_vbat_n && n < 1000) begin tick(1); n++; end
        tick(5);
        shutdown = 1'b1; tick(1); shutdown = 1'b0;
        n = 0;
        while (!ready && n < 2000) begin tick(1); n++; end
        chk("sd2_ready", 32'(ready), 32'd1);
        chk("sd2_usr_ready", 32'(bus_if.usr_ready), 32'd0);
        chk("sd2_init_count", log_n - base, 32'd12);
        tick(1);
        chk("sd2_ready_pulse", 32'(ready), 32'd0);
        chk("sd2_strobe", 32'(bus_if.spi_data_ready), 32'd1);
        chk("sd2_byte", bus_if.spi_data, 32'h000000AE);
        n = 0;
        while (!oled_vbat_n && n < 200) begin tick(1); n++; end
        chk("sd2_vbat_rise", 32'(oled_vbat_n), 32'd1);
        n = 0;
        while (!oled_vdd_n && n < 200) begin
            start = (n == 10);
            tick(1); n++;
        end
        start = 1'b0;
        chk("sd2_vdd_delay", n, 32'd50);
        tick(5);
        chk("sd2_start_ignored", 32'(oled_vdd_n), 32'd1);

        // Third power-up, asynchronous reset during the config bytes
        base = log_n;
        start = 1'b1; tick(1); start = 1'b0;
        n = 0;
        while ((log_n - base) < 7 && n < 2000) begin tick(1); n++; end
        chk("cfg_reached_vbat", 32'(oled_vbat_n), 32'd0);
        tick(3);
        resetn = 1'b0;
        #1;
        check_reset("rst_async");
        tick(2);
        resetn = 1'b1;
        tick(2);

        // Serialiser never raises busy
        model_en = 1'b0;
        base = log_n;
        start = 1'b1; tick(1); start = 1'b0;
        n = 0;
        while (!bus_if.spi_data_ready && n < 100) begin tick(1); n++; end
        chk("stuck_first", bus_if.spi_data, 32'h000000AE);
        tick(1000);
        chk("stuck_one_strobe", log_n - base, 32'd1);
        chk("stuck_strobe_low", 32'(bus_if.spi_data_ready), 32'd0);
        chk("stuck_hold", bus_if.spi_data, 32'h000000AE);
        chk("stuck_res_n", 32'(oled_res_n), 32'd1);
        chk("stuck_vbat_n", 32'(oled_vbat_n), 32'd1);
        chk("stuck_ready", 32'(ready), 32'd0);

        resetn = 1'b0;
        tick(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
